// File: rtl/cpc_mfc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpc_mfc_pkg
// Description : Shared types and constants for the CPC expansion-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package cpc_mfc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [2:0] IO_AHI_DEFAULT = 3'b111;

    // 74245 direction: 1 drives CPC -> Teensy, 0 drives Teensy -> CPC.
    localparam logic DIR_TO_T   = 1'b1;
    localparam logic DIR_TO_CPC = 1'b0;

endpackage : cpc_mfc_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser with asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/cpc_mfc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpc_mfc_bus_ctrl
// Description : Z80 bus-cycle sequencer handing claimed I/O and ROM cycles to
//               the Teensy over a four-phase req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cpc_mfc_bus_ctrl
    import cpc_mfc_pkg::*;
#(
    parameter logic [2:0] IO_AHI  = IO_AHI_DEFAULT,
    parameter int         TIMEOUT = 255,
    parameter int         CNT_W   = 8
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic [2:0] A_HI,
    input  logic       MREQ_B,
    input  logic       IOREQ_B,
    input  logic       RD_B,
    input  logic       WR_B,
    input  logic       M1_B,
    input  logic       ROMEN_B,
    input  logic       en_rom,
    input  logic       en_io,
    input  logic       t_ack,
    output logic       t_req,
    output logic       t_rnw,
    output logic       t_iom,
    output logic       t_err,
    output logic       ready_pd,
    output logic       bufoe_b,
    output logic       bufdir,
    output logic       romdis_pre
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic w_en_rom_s;
    logic w_en_io_s;
    logic w_t_ack_s;

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic             r_t_req,    w_t_req_nxt;
    logic             r_t_rnw,    w_t_rnw_nxt;
    logic             r_t_iom,    w_t_iom_nxt;
    logic             r_t_err,    w_t_err_nxt;
    logic             r_ready_pd, w_ready_pd_nxt;
    logic             r_bufoe_b,  w_bufoe_b_nxt;
    logic             r_bufdir,   w_bufdir_nxt;
    logic             r_romdis,   w_romdis_nxt;

    logic w_io_hit;
    logic w_rom_hit;
    logic w_strobe_lost;

    sync2 u_sync_en_rom (.i_clk(CLK), .i_rst_n(RESET_B), .i_d(en_rom), .o_q(w_en_rom_s));
    sync2 u_sync_en_io  (.i_clk(CLK), .i_rst_n(RESET_B), .i_d(en_io),  .o_q(w_en_io_s));
    sync2 u_sync_t_ack  (.i_clk(CLK), .i_rst_n(RESET_B), .i_d(t_ack),  .o_q(w_t_ack_s));

    // M1_B low with IOREQ_B low is interrupt acknowledge, never ours.
    assign w_io_hit  = !IOREQ_B && M1_B && (A_HI == IO_AHI) && (!RD_B || !WR_B) && w_en_io_s;
    assign w_rom_hit = !MREQ_B && !RD_B && !ROMEN_B && w_en_rom_s;

    // The strobe that claimed the cycle is chosen by the latched cycle type.
    assign w_strobe_lost = (r_t_iom ? IOREQ_B : MREQ_B) || (RD_B && WR_B);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_t_req    <= 1'b0;
            r_t_rnw    <= 1'b0;
            r_t_iom    <= 1'b0;
            r_t_err    <= 1'b0;
            r_ready_pd <= 1'b0;
            r_bufoe_b  <= 1'b1;
            r_bufdir   <= DIR_TO_T;
            r_romdis   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_t_req    <= w_t_req_nxt;
            r_t_rnw    <= w_t_rnw_nxt;
            r_t_iom    <= w_t_iom_nxt;
            r_t_err    <= w_t_err_nxt;
            r_ready_pd <= w_ready_pd_nxt;
            r_bufoe_b  <= w_bufoe_b_nxt;
            r_bufdir   <= w_bufdir_nxt;
            r_romdis   <= w_romdis_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_t_req_nxt    = r_t_req;
        w_t_rnw_nxt    = r_t_rnw;
        w_t_iom_nxt    = r_t_iom;
        w_t_err_nxt    = r_t_err;
        w_ready_pd_nxt = r_ready_pd;
        w_bufoe_b_nxt  = r_bufoe_b;
        w_bufdir_nxt   = r_bufdir;
        w_romdis_nxt   = r_romdis;

        case (r_state)
            IDLE: begin
                if (w_io_hit || w_rom_hit) begin
                    w_state_nxt    = REQ;
                    w_ready_pd_nxt = 1'b1;
                    w_t_rnw_nxt    = !RD_B;
                    w_t_iom_nxt    = w_io_hit;
                    w_romdis_nxt   = w_rom_hit && !w_io_hit;
                    w_bufdir_nxt   = !RD_B ? DIR_TO_CPC : DIR_TO_T;
                    w_bufoe_b_nxt  = 1'b0;
                end
            end

            REQ, WAIT_ACK: begin
                if (w_strobe_lost) begin
                    // Bus reset or BUSACK mid-cycle: abandon without holding the Z80.
                    w_state_nxt    = RELEASE;
                    w_ready_pd_nxt = 1'b0;
                    w_bufoe_b_nxt  = 1'b1;
                    w_romdis_nxt   = 1'b0;
                    w_t_req_nxt    = 1'b0;
                end else if (r_state == REQ) begin
                    w_state_nxt = WAIT_ACK;
                    w_t_req_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt != C_CNT_LAST) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    if (w_t_ack_s) begin
                        w_state_nxt    = HOLD;
                        w_ready_pd_nxt = 1'b0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt    = HOLD;
                        w_ready_pd_nxt = 1'b0;
                        w_t_err_nxt    = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (w_strobe_lost) begin
                    w_state_nxt   = RELEASE;
                    w_bufoe_b_nxt = 1'b1;
                    w_romdis_nxt  = 1'b0;
                    w_t_req_nxt   = 1'b0;
                end
            end

            RELEASE: begin
                if (!w_t_ack_s) begin
                    w_state_nxt  = IDLE;
                    w_bufdir_nxt = DIR_TO_T;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign t_req      = r_t_req;
    assign t_rnw      = r_t_rnw;
    assign t_iom      = r_t_iom;
    assign t_err      = r_t_err;
    assign ready_pd   = r_ready_pd;
    assign bufoe_b    = r_bufoe_b;
    assign bufdir     = r_bufdir;
    assign romdis_pre = r_romdis;

endmodule : cpc_mfc_bus_ctrl
`default_nettype wire

// File: tb/tb_cpc_mfc_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cpc_mfc_bus_ctrl
// Description : Directed self-checking bench for cpc_mfc_bus_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpc_mfc_bus_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_B;
    logic [2:0] A_HI;
    logic       MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B;
    logic       en_rom, en_io, t_ack;
    logic       t_req, t_rnw, t_iom, t_err, ready_pd, bufoe_b, bufdir, romdis_pre;

    int n_checks = 0;
    int n_errors = 0;

    cpc_mfc_bus_ctrl #(
        .IO_AHI  (3'b111),
        .TIMEOUT (255),
        .CNT_W   (8)
    ) dut (
        .CLK        (CLK),
        .RESET_B    (RESET_B),
        .A_HI       (A_HI),
        .MREQ_B     (MREQ_B),
        .IOREQ_B    (IOREQ_B),
        .RD_B       (RD_B),
        .WR_B       (WR_B),
        .M1_B       (M1_B),
        .ROMEN_B    (ROMEN_B),
        .en_rom     (en_rom),
        .en_io      (en_io),
        .t_ack      (t_ack),
        .t_req      (t_req),
        .t_rnw      (t_rnw),
        .t_iom      (t_iom),
        .t_err      (t_err),
        .ready_pd   (ready_pd),
        .bufoe_b    (bufoe_b),
        .bufdir     (bufdir),
        .romdis_pre (romdis_pre)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        MREQ_B  = 1'b1;
        IOREQ_B = 1'b1;
        RD_B    = 1'b1;
        WR_B    = 1'b1;
        M1_B    = 1'b1;
        ROMEN_B = 1'b1;
    endtask

    initial begin
        RESET_B = 1'b0;
        A_HI    = 3'b111;
        en_rom  = 1'b0;
        en_io   = 1'b0;
        t_ack   = 1'b0;
        bus_idle();

        // Reset values
        tick(2);
        chk("rst_t_req", t_req, 1'b0);
        chk("rst_t_rnw", t_rnw, 1'b0);
        chk("rst_t_iom", t_iom, 1'b0);
        chk("rst_t_err", t_err, 1'b0);
        chk("rst_ready", ready_pd, 1'b0);
        chk("rst_bufoe", bufoe_b, 1'b1);
        chk("rst_bufdir", bufdir, 1'b1);
        chk("rst_romdis", romdis_pre, 1'b0);
        RESET_B = 1'b1;
        en_io   = 1'b1;
        en_rom  = 1'b1;
        tick(3);

        // I/O write, ack 10 cycles after t_req
        IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(1);
        chk("iow_ready_first", ready_pd, 1'b1);
        chk("iow_bufoe", bufoe_b, 1'b0);
        chk("iow_bufdir", bufdir, 1'b1);
        chk("iow_rnw", t_rnw, 1'b0);
        chk("iow_iom", t_iom, 1'b1);
        chk("iow_req_not_yet", t_req, 1'b0);
        tick(1);
        chk("iow_req", t_req, 1'b1);
        tick(10);
        chk("iow_ready_wait", ready_pd, 1'b1);
        t_ack = 1'b1;
        tick(2);
        chk("iow_ready_ack2", ready_pd, 1'b1);
        tick(1);
        chk("iow_ready_ack3", ready_pd, 1'b0);
        chk("iow_hold_bufoe", bufoe_b, 1'b0);
        chk("iow_hold_req", t_req, 1'b1);
        bus_idle();
        tick(1);
        chk("iow_end_bufoe", bufoe_b, 1'b1);
        chk("iow_end_req", t_req, 1'b0);
        t_ack = 1'b0;
        tick(3);
        chk("iow_idle_bufdir", bufdir, 1'b1);

        // ROM read claimed
        MREQ_B = 1'b0; RD_B = 1'b0; ROMEN_B = 1'b0;
        tick(1);
        chk("rom_romdis", romdis_pre, 1'b1);
        chk("rom_bufdir", bufdir, 1'b0);
        chk("rom_iom", t_iom, 1'b0);
        chk("rom_rnw", t_rnw, 1'b1);
        chk("rom_ready", ready_pd, 1'b1);
        tick(1);
        t_ack = 1'b1;
        tick(3);
        chk("rom_ready_ack", ready_pd, 1'b0);
        chk("rom_hold_romdis", romdis_pre, 1'b1);
        chk("rom_hold_bufdir", bufdir, 1'b0);
        bus_idle();
        tick(1);
        chk("rom_end_romdis", romdis_pre, 1'b0);
        chk("rom_end_bufoe", bufoe_b, 1'b1);
        t_ack = 1'b0;
        tick(3);

        // ROM read with claiming disabled
        en_rom = 1'b0;
        tick(3);
        MREQ_B = 1'b0; RD_B = 1'b0; ROMEN_B = 1'b0;
        tick(4);
        chk("romoff_req", t_req, 1'b0);
        chk("romoff_ready", ready_pd, 1'b0);
        chk("romoff_romdis", romdis_pre, 1'b0);
        chk("romoff_bufoe", bufoe_b, 1'b1);
        bus_idle();
        en_rom = 1'b1;
        tick(3);

        // I/O read with no ack: timeout 255 cycles after WAIT_ACK entry
        IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(1);
        chk("to_rnw", t_rnw, 1'b1);
        chk("to_bufdir", bufdir, 1'b0);
        tick(1);
        chk("to_req", t_req, 1'b1);
        tick(254);
        chk("to_ready_254", ready_pd, 1'b1);
        chk("to_err_254", t_err, 1'b0);
        tick(1);
        chk("to_ready_255", ready_pd, 1'b0);
        chk("to_err_255", t_err, 1'b1);
        bus_idle();
        tick(1);
        chk("to_end_bufoe", bufoe_b, 1'b1);
        tick(1);

        // Good cycle after timeout; t_err stays set
        IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(2);
        t_ack = 1'b1;
        tick(3);
        chk("post_to_ready", ready_pd, 1'b0);
        bus_idle();
        tick(1);
        t_ack = 1'b0;
        tick(3);
        chk("post_to_err_sticky", t_err, 1'b1);

        // Interrupt acknowledge; RD_B driven low to isolate the M1 qualifier
        M1_B = 1'b0; IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(3);
        chk("inta_req", t_req, 1'b0);
        chk("inta_ready", ready_pd, 1'b0);
        chk("inta_bufoe", bufoe_b, 1'b1);
        bus_idle();
        tick(1);

        // Non-matching address
        A_HI = 3'b110; IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(3);
        chk("ahi_req", t_req, 1'b0);
        chk("ahi_ready", ready_pd, 1'b0);
        chk("ahi_bufoe", bufoe_b, 1'b1);
        bus_idle();
        A_HI = 3'b111;
        tick(1);

        // New cycle while ack still high in RELEASE is not claimed
        IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(2);
        t_ack = 1'b1;
        tick(3);
        chk("rel_ready_ack", ready_pd, 1'b0);
        bus_idle();
        tick(1);
        IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(3);
        chk("rel_new_ready", ready_pd, 1'b0);
        chk("rel_new_req", t_req, 1'b0);
        chk("rel_new_bufoe", bufoe_b, 1'b1);
        chk("rel_new_romdis", romdis_pre, 1'b0);
        bus_idle();
        tick(1);
        t_ack = 1'b0;
        tick(3);
        chk("rel_idle_bufdir", bufdir, 1'b1);
        chk("rel_idle_ready", ready_pd, 1'b0);

        // Reset asserted mid-WAIT_ACK clears everything, including t_err
        IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(5);
        chk("mid_ready", ready_pd, 1'b1);
        chk("mid_req", t_req, 1'b1);
        #2 RESET_B = 1'b0;
        #1;
        chk("mid_rst_req", t_req, 1'b0);
        chk("mid_rst_ready", ready_pd, 1'b0);
        chk("mid_rst_bufoe", bufoe_b, 1'b1);
        chk("mid_rst_bufdir", bufdir, 1'b1);
        chk("mid_rst_iom", t_iom, 1'b0);
        chk("mid_rst_err", t_err, 1'b0);
        bus_idle();
        tick(2);
        RESET_B = 1'b1;
        tick(3);
        chk("after_rst_ready", ready_pd, 1'b0);
        chk("after_rst_bufoe", bufoe_b, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpc_mfc_bus_ctrl
`default_nettype wire

// File: doc/cpc_mfc_bus_ctrl.md
Name: cpc_mfc_bus_ctrl

Overview:
- CPLD-resident sequencer for the CPC expansion-bus bridge between the Z80 bus and the Teensy co-processor.
- Decodes Z80 I/O cycles and ROM reads claimed by the board.
- Holds the Z80 in wait states via READY while the Teensy services the cycle over a four-phase req/ack handshake.
- Drives the 74245 data buffer enable and direction, and the ROMDIS pre-diode signal.

Parameters:
- IO_AHI, 3'b111: A15..A13 match value for claimed I/O cycles.
- TIMEOUT, 255: CLK cycles allowed for the Teensy ack before forced release.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- CLK  in  1  CPC Z80 clock (4 MHz); all state on rising edge.
- RESET_B  in  1  asynchronous active-low reset.
- A_HI  in  3  A15..A13.
- MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B  in  1 each  Z80/gate-array strobes, active low.
- en_rom  in  1  from Teensy; enables ROM-read claiming (async, synchronised).
- en_io  in  1  from Teensy; enables I/O claiming (async, synchronised).
- t_ack  in  1  Teensy acknowledge (async, synchronised).
- t_req  out  1  request to Teensy.
- t_rnw  out  1  1 = read cycle, valid while t_req=1.
- t_iom  out  1  1 = I/O cycle, 0 = ROM read; valid while t_req=1.
- t_err  out  1  sticky timeout flag; cleared only by reset.
- ready_pd  out  1  1 = pull CPC READY low (insert wait).
- bufoe_b  out  1  74245 enable, active low.
- bufdir  out  1  1 = CPC to Teensy (writes), 0 = Teensy to CPC (reads).
- romdis_pre  out  1  drives ROMDIS through the diode.

Behaviour:
- Reset values (async, RESET_B=0): t_req=0, t_rnw=0, t_iom=0, t_err=0, ready_pd=0, bufoe_b=1, bufdir=1, romdis_pre=0, state=IDLE, counter=0, synchroniser flops=0.
- Synchronisers: en_rom, en_io and t_ack each pass through 2 flops. Decode and FSM use only the synchronised copies.
- Decode, sampled at rising edge in IDLE:
  - io_hit = !IOREQ_B & M1_B & (A_HI==IO_AHI) & (!RD_B | !WR_B) & en_io_s.
  - rom_hit = !MREQ_B & !RD_B & !ROMEN_B & en_rom_s.
  - io_hit has priority; the two cannot coexist on a legal bus.
  - Interrupt acknowledge (M1_B=0 with IOREQ_B=0) is never claimed.
- FSM states: IDLE, REQ, WAIT_ACK, HOLD, RELEASE.
- IDLE:
  - On a hit, go to REQ; ready_pd=1 from the same edge, so READY is low before the T2 falling edge.
  - Latch t_rnw=!RD_B and t_iom=io_hit.
  - romdis_pre=1 immediately on rom_hit.
  - bufdir=!t_rnw; bufoe_b=0.
- REQ: t_req=1, counter cleared, then go to WAIT_ACK.
- WAIT_ACK:
  - Counter increments each cycle.
  - t_ack_s=1: go to HOLD with ready_pd=0.
  - counter==TIMEOUT-1 without ack: t_err=1, ready_pd=0, go to HOLD. On reads, the bus then carries whatever the Teensy drives.
- HOLD:
  - Keep bufoe_b=0 and romdis_pre as latched.
  - When the claiming strobe deasserts (IOREQ_B or MREQ_B high, or both RD_B and WR_B high): bufoe_b=1, romdis_pre=0, t_req=0, go to RELEASE.
- RELEASE:
  - Wait for t_ack_s=0, then go to IDLE and restore bufdir=1.
  - A new bus cycle arriving in RELEASE is not claimed. The Teensy must drop ack within one Z80 cycle; otherwise the miss is a documented limitation.
- Strobe loss in REQ/WAIT_ACK (bus reset, BUSACK): deassert ready_pd, bufoe_b and romdis_pre at once, drop t_req, go to RELEASE.
- Latency: strobe seen at edge n gives ready_pd=1 at edge n and t_req=1 at n+1. t_ack visible at the pin reaches ready_pd=0 two to three edges later (two synchroniser flops plus FSM).
- Counter saturates at TIMEOUT-1; it never wraps.
- Outputs are registered; none are combinational from inputs.

Decomposition:
- Shared package cpc_mfc_pkg holds:
  - the state enum (IDLE, REQ, WAIT_ACK, HOLD, RELEASE);
  - the default IO_AHI constant;
  - the buffer direction constants DIR_TO_T=1 and DIR_TO_CPC=0.
- One sub-module, sync2: a 2-flop synchroniser with async active-low clear, instantiated three times.

Test Plan:
- Reset held low mid-WAIT_ACK, then released -> all outputs at reset values within the reset; FSM in IDLE; t_err=0.
- I/O write, A_HI=3'b111, en_io=1; ack asserted 10 cycles after t_req -> ready_pd=1 from first edge; bufdir=1, bufoe_b=0; t_rnw=0, t_iom=1; ready_pd drops ≤3 edges after ack; bufoe_b=1 when IOREQ_B rises.
- ROM read with ROMEN_B=0, en_rom=1 -> romdis_pre=1 and bufdir=0 throughout; t_iom=0; romdis_pre=0 on MREQ_B rise.
- Same ROM read with en_rom=0 -> no claim: t_req, ready_pd and romdis_pre stay 0; bufoe_b stays 1.
- I/O read with no ack, TIMEOUT=255 -> ready_pd released at exactly 255 cycles after WAIT_ACK entry; t_err=1 and sticky across subsequent good cycles.
- Interrupt acknowledge (M1_B=0, IOREQ_B=0, A_HI=3'b111); I/O with A_HI=3'b110; and a cycle started while t_ack is still high in RELEASE -> none claimed; all outputs idle.
